// File: rtl/seq_pattern_detector.sv
// Serial pattern detector built on a KMP prefix automaton. The transition table is
// derived from P_PATTERN at elaboration time, and every output comes from a register.
module seq_pattern_detector #(
    parameter int               P_LEN       = 4,
    parameter logic [P_LEN-1:0] P_PATTERN   = 4'b1011,
    parameter bit               P_OVERLAP   = 1'b1,
    parameter bit               P_STICKY    = 1'b0,
    parameter int               P_CNT_WIDTH = 8,
    localparam int              PW          = $clog2(P_LEN + 1)
) (
    input  logic                   i_w_clk,
    input  logic                   i_w_reset,
    input  logic                   i_w_in,
    input  logic                   i_w_valid,
    input  logic                   i_w_clear,
    output logic                   o_w_match,
    output logic [P_CNT_WIDTH-1:0] o_w_count,
    output logic [PW-1:0]          o_w_progress
);

    localparam int                     TAB_N   = 1 << PW;
    localparam logic [P_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = P_CNT_WIDTH'(1);
    localparam logic [PW-1:0]          LEN_K   = PW'(P_LEN);

    // Bit i of the pattern, where i = 0 is the first bit expected (the MSB).
    function automatic logic pat_bit(input int i);
        logic [P_LEN-1:0] t;
        t = P_PATTERN >> (P_LEN - 1 - i);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (prefix_k followed by b).
    function automatic logic [PW-1:0] calc_next(input int k, input logic b);
        int   best;
        logic ok;
        logic s_bit;
        best = 0;
        for (int l = 1; l <= P_LEN; l++) begin
            if (l <= k + 1) begin
                ok = 1'b1;
                for (int j = 0; j < P_LEN; j++) begin
                    if (j < l) begin
                        s_bit = (k + 1 - l + j < k) ? pat_bit(k + 1 - l + j) : b;
                        if (pat_bit(j) != s_bit) ok = 1'b0;
                    end
                end
                if (ok) best = l;
            end
        end
        return PW'(best);
    endfunction

    // Longest proper prefix of the pattern that is also one of its suffixes.
    function automatic logic [PW-1:0] calc_fail();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < P_LEN; l++) begin
            ok = 1'b1;
            for (int j = 0; j < P_LEN; j++) begin
                if (j < l && pat_bit(j) != pat_bit(P_LEN - l + j)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return PW'(best);
    endfunction

    localparam logic [PW-1:0] FAIL_LEN = calc_fail();

    logic [PW-1:0] next_tab0 [TAB_N];
    logic [PW-1:0] next_tab1 [TAB_N];

    for (genvar g = 0; g < TAB_N; g++) begin : g_tab
        if (g < P_LEN) begin : g_live
            assign next_tab0[g] = calc_next(g, 1'b0);
            assign next_tab1[g] = calc_next(g, 1'b1);
        end else begin : g_pad
            assign next_tab0[g] = '0;
            assign next_tab1[g] = '0;
        end
    end

    logic [PW-1:0]          k_q, k_d, k_cand;
    logic                   match_q, match_d;
    logic [P_CNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            k_q     <= '0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            k_q     <= k_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        k_d     = k_q;
        match_d = P_STICKY ? match_q : 1'b0;
        count_d = count_q;
        k_cand  = i_w_in ? next_tab1[k_q] : next_tab0[k_q];
        if (i_w_clear) begin
            k_d     = '0;
            match_d = 1'b0;
            count_d = '0;
        end else if (i_w_valid) begin
            if (k_cand == LEN_K) begin
                match_d = 1'b1;
                k_d     = P_OVERLAP ? FAIL_LEN : '0;
                if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
            end else begin
                k_d = k_cand;
            end
        end
    end

    always_comb begin
        o_w_match    = match_q;
        o_w_count    = count_q;
        o_w_progress = k_q;
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: four configurations share one stimulus bus, and each
// scenario task checks one instance against a brute-force history model.
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_b, valid, clr;

    logic       ov_match, no_match, st_match, sat_match;
    logic [7:0] ov_count, no_count, st_count;
    logic [1:0] sat_count;
    logic [2:0] ov_prog, no_prog;
    logic [1:0] st_prog;
    logic [0:0] sat_prog;

    seq_pattern_detector #(.P_LEN(4), .P_PATTERN(4'b1011), .P_OVERLAP(1'b1), .P_STICKY(1'b0),
                           .P_CNT_WIDTH(8)) dut_ov (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in_b), .i_w_valid(valid), .i_w_clear(clr),
        .o_w_match(ov_match), .o_w_count(ov_count), .o_w_progress(ov_prog));

    seq_pattern_detector #(.P_LEN(4), .P_PATTERN(4'b1011), .P_OVERLAP(1'b0), .P_STICKY(1'b0),
                           .P_CNT_WIDTH(8)) dut_no (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in_b), .i_w_valid(valid), .i_w_clear(clr),
        .o_w_match(no_match), .o_w_count(no_count), .o_w_progress(no_prog));

    seq_pattern_detector #(.P_LEN(2), .P_PATTERN(2'b10), .P_OVERLAP(1'b1), .P_STICKY(1'b1),
                           .P_CNT_WIDTH(8)) dut_st (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in_b), .i_w_valid(valid), .i_w_clear(clr),
        .o_w_match(st_match), .o_w_count(st_count), .o_w_progress(st_prog));

    seq_pattern_detector #(.P_LEN(1), .P_PATTERN(1'b1), .P_OVERLAP(1'b1), .P_STICKY(1'b0),
                           .P_CNT_WIDTH(2)) dut_sat (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in_b), .i_w_valid(valid), .i_w_clear(clr),
        .o_w_match(sat_match), .o_w_count(sat_count), .o_w_progress(sat_prog));

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] exp_q[$];

    // Model configuration and state: the model keeps the raw history of accepted bits.
    int          c_len, c_cw;
    logic [31:0] c_pat;
    logic        c_ovl, c_sticky;
    logic [63:0] m_hist;
    int          m_hlen, m_cnt;
    logic        m_match;

    function automatic logic [11:0] obs(input int sel);
        case (sel)
            0:       return {ov_match, ov_count, ov_prog};
            1:       return {no_match, no_count, no_prog};
            2:       return {st_match, st_count, 1'b0, st_prog};
            default: return {sat_match, 6'd0, sat_count, 2'b00, sat_prog};
        endcase
    endfunction

    task automatic set_cfg(input int sel);
        case (sel)
            0: begin c_len = 4; c_pat = 32'b1011; c_ovl = 1; c_sticky = 0; c_cw = 8; end
            1: begin c_len = 4; c_pat = 32'b1011; c_ovl = 0; c_sticky = 0; c_cw = 8; end
            2: begin c_len = 2; c_pat = 32'b10;   c_ovl = 1; c_sticky = 1; c_cw = 8; end
            default: begin c_len = 1; c_pat = 32'b1; c_ovl = 1; c_sticky = 0; c_cw = 2; end
        endcase
    endtask

    task automatic model_rst();
        m_hist = '0; m_hlen = 0; m_cnt = 0; m_match = 1'b0;
    endtask

    // True when the last l accepted bits equal the first l pattern bits.
    function automatic logic tail_is_prefix(input int l);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < l; j++)
            if (m_hist[j] != c_pat[c_len - l + j]) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_cycle(input logic b, input logic v, input logic c, input logic r,
                               output logic [11:0] e);
        logic hit;
        int   best;
        if (r || c) begin
            model_rst();
        end else if (v) begin
            m_hist = {m_hist[62:0], b};
            m_hlen++;
            hit = (m_hlen >= c_len) && tail_is_prefix(c_len);
            if (!c_sticky) m_match = hit;
            else if (hit) m_match = 1'b1;
            if (hit && m_cnt < (1 << c_cw) - 1) m_cnt++;
            if (hit && !c_ovl) m_hlen = 0;
        end else if (!c_sticky) begin
            m_match = 1'b0;
        end
        best = 0;
        for (int l = 1; l < c_len; l++)
            if (l <= m_hlen && tail_is_prefix(l)) best = l;
        e = {m_match, 8'(m_cnt), 3'(best)};
    endtask

    task automatic step(input logic b, input logic v, input logic c, input logic r);
        @(negedge clk);
        in_b = b; valid = v; clr = c; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sel);
        set_cfg(sel);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        model_rst();
    endtask

    task automatic test_reset();
        logic [11:0] e, got;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back(12'd0);
            e = exp_q.pop_front();
            got = obs(s);
            n_checks++;
            if (got !== e) $display("FAIL reset dut%0d: got %h expected %h", s, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_overlap();
        logic [6:0]  stream = 7'b1011011;
        logic [11:0] e, got;
        do_reset(0);
        for (int i = 6; i >= 0; i--) begin
            model_cycle(stream[i], 1'b1, 1'b0, 1'b0, e);
            exp_q.push_back(e);
            step(stream[i], 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = obs(0);
            n_checks++;
            if (got !== e) $display("FAIL overlap s%0d: got %h expected %h", 7 - i, got, e);
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (ov_prog !== 3'd1) $display("FAIL overlap_prog4: got %0d expected 1", ov_prog);
                else n_pass++;
            end
        end
        n_checks++;
        if (ov_count !== 8'd2) $display("FAIL overlap_count: got %0d expected 2", ov_count);
        else n_pass++;
    endtask

    task automatic test_no_overlap();
        logic [6:0]  stream = 7'b1011011;
        logic [11:0] e, got;
        do_reset(1);
        for (int i = 6; i >= 0; i--) begin
            model_cycle(stream[i], 1'b1, 1'b0, 1'b0, e);
            exp_q.push_back(e);
            step(stream[i], 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = obs(1);
            n_checks++;
            if (got !== e) $display("FAIL no_overlap s%0d: got %h expected %h", 7 - i, got, e);
            else n_pass++;
        end
        n_checks++;
        if (no_count !== 8'd1 || no_prog !== 3'd1)
            $display("FAIL no_overlap_end: got count %0d prog %0d expected 1 1", no_count, no_prog);
        else n_pass++;
    endtask

    task automatic test_sticky_clear();
        logic [6:0]  stream = 7'b0011010;
        logic [11:0] e, got;
        do_reset(2);
        for (int i = 6; i >= 0; i--) begin
            model_cycle(stream[i], 1'b1, 1'b0, 1'b0, e);
            exp_q.push_back(e);
            step(stream[i], 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = obs(2);
            n_checks++;
            if (got !== e) $display("FAIL sticky s%0d: got %h expected %h", 7 - i, got, e);
            else n_pass++;
        end
        n_checks++;
        if (st_match !== 1'b1 || st_count !== 8'd2)
            $display("FAIL sticky_end: got match %0b count %0d expected 1 2", st_match, st_count);
        else n_pass++;
        model_cycle(1'b1, 1'b0, 1'b1, 1'b0, e);
        exp_q.push_back(e);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        got = obs(2);
        n_checks++;
        if (got !== e || got !== 12'd0) $display("FAIL sticky_clear: got %h expected 000", got);
        else n_pass++;
    endtask

    task automatic test_valid_gating();
        logic [3:0]  pat = 4'b1011;
        logic [11:0] e, got;
        logic        b;
        int          pulses = 0;
        do_reset(0);
        for (int i = 3; i >= 0; i--) begin
            for (int g = 0; g < 4; g++) begin
                b = (g == 0) ? pat[i] : 1'($urandom_range(0, 1));
                model_cycle(b, g == 0, 1'b0, 1'b0, e);
                exp_q.push_back(e);
                step(b, g == 0, 1'b0, 1'b0);
                e = exp_q.pop_front();
                got = obs(0);
                if (ov_match === 1'b1) pulses++;
                n_checks++;
                if (got !== e) $display("FAIL gating b%0d g%0d: got %h expected %h", i, g, got, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (pulses !== 1) $display("FAIL gating_pulses: got %0d expected 1", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        // Columns: in, valid, clear, reset.
        logic [3:0]  stim [10] = '{4'b1100, 4'b0100, 4'b1100, 4'b1101, 4'b0100, 4'b1100,
                                   4'b1100, 4'b0100, 4'b1100, 4'b1110};
        logic [11:0] e, got;
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            model_cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0], e);
            exp_q.push_back(e);
            step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            e = exp_q.pop_front();
            got = obs(0);
            n_checks++;
            if (got !== e) $display("FAIL reset_mid c%0d: got %h expected %h", i, got, e);
            else n_pass++;
            if (i == 3 || i == 9) begin
                n_checks++;
                if (got !== 12'd0) $display("FAIL reset_mid_zero c%0d: got %h expected 000", i, got);
                else n_pass++;
            end
        end
        n_checks++;
        if (ov_count !== 8'd0) $display("FAIL reset_mid_count: got %0d expected 0", ov_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [1:0]  exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [11:0] e, got;
        do_reset(3);
        for (int i = 0; i < 5; i++) begin
            model_cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
            exp_q.push_back(e);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = obs(3);
            n_checks++;
            if (got !== e || sat_count !== exp_cnt[i] || sat_match !== 1'b1)
                $display("FAIL saturation s%0d: got match %0b count %0d expected 1 %0d",
                         i + 1, sat_match, sat_count, exp_cnt[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random(input int sel);
        logic [11:0] e, got;
        logic        b, v, c;
        do_reset(sel);
        for (int i = 0; i < 300; i++) begin
            b = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            model_cycle(b, v, c, 1'b0, e);
            exp_q.push_back(e);
            step(b, v, c, 1'b0);
            e = exp_q.pop_front();
            got = obs(sel);
            n_checks++;
            if (got !== e) $display("FAIL random dut%0d c%0d: got %h expected %h", sel, i, got, e);
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_b = 1'b0; valid = 1'b0; clr = 1'b0;
        set_cfg(0);
        model_rst();
        test_reset();
        test_overlap();
        test_no_overlap();
        test_sticky_clear();
        test_valid_gating();
        test_reset_mid();
        test_saturation();
        test_random(0);
        test_random(1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
